// File: rtl/wb_pipe_master_if.sv
// Command, response and Wishbone pipelined bus bundle for wb_pipe_master.
// Signal suffixes are relative to the master: *_i flows into it, *_o flows out.
interface wb_pipe_master_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_W-1:0]     cmd_addr_i;
    logic [DATA_W/8-1:0]   cmd_sel_i;
    logic [DATA_W-1:0]     cmd_data_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_data_o;
    logic                  rsp_we_o;
    logic                  rsp_err_o;

    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_W-1:0]     wb_addr_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic [DATA_W-1:0]     wb_data_o;
    logic                  wb_stall_i;
    logic                  wb_ack_i;
    logic [DATA_W-1:0]     wb_data_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_sel_i, cmd_data_i,
        output cmd_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_data_o, rsp_we_o, rsp_err_o,
        output wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o,
        input  wb_stall_i, wb_ack_i, wb_data_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_sel_i, cmd_data_i,
        input  cmd_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_data_o, rsp_we_o, rsp_err_o,
        input  wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o,
        output wb_stall_i, wb_ack_i, wb_data_i
    );
endinterface

// File: rtl/wb_pipe_master.sv
// Single-outstanding Wishbone pipelined master: command -> bus request -> response.
// Optional ack timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_pipe_master #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    wb_pipe_master_if.master bus
);
    localparam int unsigned SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                w_cmd_ready;
    logic                w_cmd_fire;
    logic                w_req_fire;
    logic                w_ack_fire;
    logic                w_timeout;

    logic                r_wb_we;
    logic [ADDR_W-1:0]   r_wb_addr;
    logic [SEL_W-1:0]    r_wb_sel;
    logic [DATA_W-1:0]   r_wb_data;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_we;

    if (TIMEOUT_CYC < 3) begin : g_timeout_range
        $error("wb_pipe_master: TIMEOUT_CYC must be at least 3");
    end

    // Ready is masked by reset so no command can be offered while held in reset.
    assign w_cmd_ready = (r_state == IDLE) && rst_n_i;
    assign w_cmd_fire  = w_cmd_ready && bus.cmd_valid_i;
    assign w_req_fire  = (r_state == REQ) && !bus.wb_stall_i;
    assign w_ack_fire  = (r_state == WAIT_ACK) && bus.wb_ack_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (bus.cmd_valid_i)             w_next = REQ;
            REQ:      if (!bus.wb_stall_i)             w_next = WAIT_ACK;
            WAIT_ACK: if (bus.wb_ack_i || w_timeout)   w_next = RESP;
            RESP:     if (bus.rsp_ready_i)             w_next = IDLE;
            default:                                   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_sel   <= '0;
            r_wb_data  <= '0;
            r_rsp_data <= '0;
            r_rsp_we   <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_wb_we   <= bus.cmd_we_i;
                r_wb_addr <= bus.cmd_addr_i;
                r_wb_sel  <= bus.cmd_sel_i;
                r_wb_data <= bus.cmd_we_i ? bus.cmd_data_i : {DATA_W{1'b0}};
            end
            if (w_ack_fire) begin
                r_rsp_data <= r_wb_we ? {DATA_W{1'b0}} : bus.wb_data_i;
                r_rsp_we   <= r_wb_we;
            end else if (w_timeout) begin
                r_rsp_data <= '0;
                r_rsp_we   <= r_wb_we;
            end
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYC > 3) ? TIMEOUT_CYC - 3 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_rsp_err;

    // Threshold is offset by the IDLE->REQ->WAIT_ACK cycles so an unstalled,
    // unacked request reports its error TIMEOUT_CYC cycles after command accept.
    assign w_timeout = (r_state == WAIT_ACK) && !bus.wb_ack_i && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_to_cnt <= '0;
        end else if ((r_state != WAIT_ACK) || bus.wb_ack_i) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rsp_err <= 1'b0;
        end else if (w_ack_fire) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign bus.rsp_err_o = r_rsp_err;
`else
    assign w_timeout     = 1'b0;
    assign bus.rsp_err_o = 1'b0;
`endif

    assign bus.cmd_ready_o = w_cmd_ready;
    assign bus.wb_stb_o    = (r_state == REQ);
    assign bus.wb_we_o     = r_wb_we;
    assign bus.wb_addr_o   = r_wb_addr;
    assign bus.wb_sel_o    = r_wb_sel;
    assign bus.wb_data_o   = r_wb_data;
    assign bus.rsp_valid_o = (r_state == RESP);
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.rsp_we_o    = r_rsp_we;
endmodule

// File: tb/tb_wb_pipe_master.sv
// Self-checking bench for wb_pipe_master: directed vector table, reset/timeout
// sequences and randomized transactions against a transaction-level memory model.
module tb_wb_pipe_master;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;
    localparam int          NV = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_pipe_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_pipe_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
        int            stall;
        int            ack_dly;
        int            rdy_dly;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t          vecs [NV];
    logic [DW-1:0] slv_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < int'(SW); b++)
            if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, bus.cmd_ready_o, 0);
        chk({tag, " wb_stb"},    bus.wb_stb_o,    0);
        chk({tag, " wb_we"},     bus.wb_we_o,     0);
        chk({tag, " wb_addr"},   bus.wb_addr_o,   0);
        chk({tag, " wb_sel"},    bus.wb_sel_o,    0);
        chk({tag, " wb_data"},   bus.wb_data_o,   0);
        chk({tag, " rsp_valid"}, bus.rsp_valid_o, 0);
        chk({tag, " rsp_we"},    bus.rsp_we_o,    0);
        chk({tag, " rsp_err"},   bus.rsp_err_o,   0);
        chk({tag, " rsp_data"},  bus.rsp_data_o,  0);
    endtask

    // One command end to end; the bench plays Wishbone slave and response sink.
    // ack_dly < 0 means the slave never acks. Cycle k counts from command accept.
    task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [SW-1:0] sel, input logic [DW-1:0] data,
                           input int stall, input int ack_dly, input int rdy_dly,
                           input logic [DW-1:0] exp_data, input logic exp_err, input int exp_lat);
        int            k, stb_cnt, rsp_cnt, rsp_first, ack_at, stall_left;
        logic          hs, slv_we;
        logic [AW-1:0] slv_addr;
        logic [DW-1:0] exp_wdata;
        exp_wdata  = we ? data : '0;
        slv_we     = 1'b0;
        slv_addr   = '0;
        @(negedge clk);
        chk({tag, " cmd_ready idle"}, bus.cmd_ready_o, 1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_sel_i   = sel;
        bus.cmd_data_i  = data;
        bus.wb_ack_i    = 1'($urandom_range(0, 1));
        bus.wb_data_i   = $urandom;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'($urandom_range(0, 1));
        bus.cmd_addr_i  = AW'($urandom);
        bus.cmd_sel_i   = SW'($urandom);
        bus.cmd_data_i  = $urandom;
        k = 1; stb_cnt = 0; rsp_cnt = 0; rsp_first = 0; ack_at = -1;
        stall_left = stall; hs = 1'b0;
        while (!hs && k < 200) begin
            bus.wb_ack_i    = 1'b0;
            bus.wb_stall_i  = 1'b0;
            bus.rsp_ready_i = 1'b0;
            bus.wb_data_i   = $urandom;
            chk({tag, " cmd_ready busy"}, bus.cmd_ready_o, 0);
            if (bus.wb_stb_o) begin
                stb_cnt++;
                chk({tag, " wb_addr"}, bus.wb_addr_o, addr);
                chk({tag, " wb_we"},   bus.wb_we_o,   we);
                chk({tag, " wb_sel"},  bus.wb_sel_o,  sel);
                chk({tag, " wb_data"}, bus.wb_data_o, exp_wdata);
                if (stall_left > 0) begin
                    bus.wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    ack_at   = (ack_dly < 0) ? -1 : k + 1 + ack_dly;
                    slv_we   = bus.wb_we_o;
                    slv_addr = bus.wb_addr_o;
                    if (bus.wb_we_o)
                        slv_mem[bus.wb_addr_o] = merge(slv_mem[bus.wb_addr_o], bus.wb_data_o, bus.wb_sel_o);
                end
                bus.wb_ack_i = 1'($urandom_range(0, 1));
            end else if (k == ack_at) begin
                bus.wb_ack_i  = 1'b1;
                bus.wb_data_i = slv_we ? $urandom : slv_mem[slv_addr];
            end
            if (bus.rsp_valid_o) begin
                if (rsp_cnt == 0) rsp_first = k;
                chk({tag, " rsp_data"}, bus.rsp_data_o, exp_data);
                chk({tag, " rsp_we"},   bus.rsp_we_o,   we);
                chk({tag, " rsp_err"},  bus.rsp_err_o,  exp_err);
                rsp_cnt++;
                if (rsp_cnt > rdy_dly) begin
                    bus.rsp_ready_i = 1'b1;
                    hs = 1'b1;
                end
                bus.wb_ack_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        bus.rsp_ready_i = 1'b0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_stall_i  = 1'b0;
        chk({tag, " response seen"}, hs, 1);
        chk({tag, " stb cycles"},    stb_cnt, stall + 1);
        chk({tag, " rsp latency"},   rsp_first, exp_lat);
        chk({tag, " rsp cycles"},    rsp_cnt, rdy_dly + 1);
        chk({tag, " single rsp"},    bus.rsp_valid_o, 0);
        chk({tag, " ready again"},   bus.cmd_ready_o, 1);
        if (we) ref_mem[addr] = merge(ref_mem[addr], data, sel);
    endtask

    function automatic int ack_latency(input int stall, input int ack_dly);
        return 3 + stall + ack_dly;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        bus.cmd_valid_i = 1'b0; bus.cmd_we_i   = 1'b0; bus.cmd_addr_i = '0;
        bus.cmd_sel_i   = '0;   bus.cmd_data_i = '0;   bus.rsp_ready_i = 1'b0;
        bus.wb_stall_i  = 1'b0; bus.wb_ack_i   = 1'b0; bus.wb_data_i  = '0;

        //                 we    addr    sel   data          stall ack rdy  exp_data
        vecs[0] = '{1'b1, 9'h045, 4'hF, 32'hCAFEBABE, 0, 0, 0, 32'h0};
        vecs[1] = '{1'b0, 9'h045, 4'hF, 32'h0,        0, 0, 0, 32'hCAFEBABE};
        vecs[2] = '{1'b1, 9'h100, 4'hF, 32'h12345678, 2, 1, 0, 32'h0};
        vecs[3] = '{1'b1, 9'h1FF, 4'hC, 32'hA5A55A5A, 0, 0, 0, 32'h0};
        vecs[4] = '{1'b0, 9'h1FF, 4'hF, 32'h0,        0, 2, 4, 32'hA5A50000};
        vecs[5] = '{1'b1, 9'h000, 4'h3, 32'h0000BEEF, 1, 0, 1, 32'h0};
        vecs[6] = '{1'b0, 9'h000, 4'hF, 32'h0,        0, 3, 0, 32'h0000BEEF};
        vecs[7] = '{1'b0, 9'h100, 4'h5, 32'h0,        3, 0, 2, 32'h12345678};
        vecs[8] = '{1'b1, 9'h045, 4'h2, 32'h00001100, 0, 0, 0, 32'h0};
        vecs[9] = '{1'b0, 9'h045, 4'hF, 32'h0,        0, 0, 0, 32'hCAFE11BE};

        #12;
        chk_reset_outputs("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready after release", bus.cmd_ready_o, 1);

        for (int i = 0; i < NV; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data,
                    vecs[i].stall, vecs[i].ack_dly, vecs[i].rdy_dly, vecs[i].exp_data, 1'b0,
                    ack_latency(vecs[i].stall, vecs[i].ack_dly));

        // Reset while waiting for ack, then a late ack that must be ignored.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_addr_i = 9'h0AA; bus.cmd_sel_i = 4'hF;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        chk("rst seq stb in REQ", bus.wb_stb_o, 1);
        @(negedge clk);
        chk("rst seq stb in WAIT_ACK", bus.wb_stb_o, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid-txn reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_ack_i  = 1'b1;
        bus.wb_data_i = 32'hDEADBEEF;
        #1 chk("ready after mid-txn reset", bus.cmd_ready_o, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.wb_ack_i = 1'b0;
            chk("late ack rsp_valid", bus.rsp_valid_o, 0);
            chk("late ack rsp_data",  bus.rsp_data_o,  0);
            chk("late ack stb",       bus.wb_stb_o,    0);
        end
        run_txn("after reset", 1'b0, 9'h045, 4'hF, 32'h0, 0, 0, 0, ref_mem[9'h045], 1'b0,
                ack_latency(0, 0));

`ifdef WB_MASTER_TIMEOUT_EN
        run_txn("timeout", 1'b0, 9'h001, 4'hF, 32'h0, 0, -1, 0, 32'h0, 1'b1, TO);
        run_txn("timeout stalled", 1'b1, 9'h002, 4'hF, 32'h11223344, 2, -1, 1, 32'h0, 1'b1, TO + 2);
        slv_mem[9'h002] = ref_mem[9'h002];
`else
        run_txn("long wait", 1'b0, 9'h001, 4'hF, 32'h0, 0, 40, 0, ref_mem[9'h001], 1'b0,
                ack_latency(0, 40));
`endif

        for (int t = 0; t < 60; t++) begin
            logic          we;
            logic [AW-1:0] addr;
            logic [SW-1:0] sel;
            logic [DW-1:0] data;
            int            st, ad, rd;
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            sel  = SW'($urandom_range(1, 15));
            data = $urandom;
            st   = $urandom_range(0, 3);
            ad   = $urandom_range(0, 5);
            rd   = $urandom_range(0, 3);
            run_txn($sformatf("rand%0d", t), we, addr, sel, data, st, ad, rd,
                    we ? 32'h0 : ref_mem[addr], 1'b0, ack_latency(st, ad));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
